// File: rtl/othello_pkg.sv
// rtl/othello_pkg.sv - shared othello drawing types and screen geometry
// Purpose: coordinate widths, plothelper select codes and plot scheduler states.
// Ports: none (package).
package othello_pkg;

  localparam int X_W = 8;  // 160-pixel wide screen
  localparam int Y_W = 7;  // 120-pixel tall screen

  typedef enum logic [1:0] {
    SEL_EMPTY  = 2'b00,
    SEL_BLACK  = 2'b01,
    SEL_WHITE  = 2'b10,
    SEL_CURSOR = 2'b11
  } select_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    ACK
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin request picker
// Purpose: first requester at or after pointer, wrapping modulo NUM_REQ.
// Ports:
//   req       in  NUM_REQ  request vector
//   pointer   in  IDX_W    index with highest priority this round
//   grant     out NUM_REQ  one-hot winner (all zero when no request)
//   grant_idx out IDX_W    encoded winner index
//   valid     out 1        at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               valid
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = '0;
    // Walk offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(pointer) + off) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/plot_scheduler.sv
// rtl/plot_scheduler.sv - round-robin sharing of the plothelper cell-draw port
// Purpose: grants one cell-draw job at a time, holds plot_en for CELL_CYCLES,
//          then pulses ack to the job owner.
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   req                     per-requester job request, held until ack
//   x_req, y_req, sel_req   flattened per-requester payload lanes
//   ack                     one-cycle completion pulse to the owner
//   plot_en, x_plot, y_plot, select   plothelper drive
//   busy                    job in progress (DRAW or ACK)
//   owner                   current or last granted requester
module plot_scheduler #(
  parameter int NUM_REQ     = 3,
  parameter int X_W         = othello_pkg::X_W,
  parameter int Y_W         = othello_pkg::Y_W,
  parameter int CELL_CYCLES = 256
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*X_W-1:0] x_req,
  input  logic [NUM_REQ*Y_W-1:0] y_req,
  input  logic [NUM_REQ*2-1:0]   sel_req,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   plot_en,
  output logic [X_W-1:0]         x_plot,
  output logic [Y_W-1:0]         y_plot,
  output logic [1:0]             select,
  output logic                   busy,
  output logic [1:0]             owner
);

  import othello_pkg::*;

  localparam int CW = (CELL_CYCLES > 1) ? $clog2(CELL_CYCLES) : 1;

  sched_state_t       state;
  logic [CW-1:0]      count;
  logic [1:0]         pointer;

  logic [NUM_REQ-1:0] grant;
  logic [1:0]         grant_idx;
  logic               grant_valid;
  logic [X_W-1:0]     win_x;
  logic [Y_W-1:0]     win_y;
  logic [1:0]         win_sel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (2)
  ) u_arb (
    .req       (req),
    .pointer   (pointer),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (grant_valid)
  );

  // Winner's payload lanes, muxed by the one-hot grant.
  always_comb begin
    win_x   = '0;
    win_y   = '0;
    win_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_x   = x_req[i*X_W +: X_W];
        win_y   = y_req[i*Y_W +: Y_W];
        win_sel = sel_req[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      pointer <= '0;
      plot_en <= 1'b0;
      ack     <= '0;
      busy    <= 1'b0;
      owner   <= '0;
      x_plot  <= '0;
      y_plot  <= '0;
      select  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (grant_valid) begin
            x_plot  <= win_x;
            y_plot  <= win_y;
            select  <= win_sel;
            owner   <= grant_idx;
            plot_en <= 1'b1;
            busy    <= 1'b1;
            count   <= '0;
            pointer <= (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
            state   <= DRAW;
          end else begin
            plot_en <= 1'b0;
            busy    <= 1'b0;
          end
        end
        DRAW: begin
          count <= count + 1'b1;
          // Counter is 0 on the first enabled cycle, so CELL_CYCLES-1 is the last.
          if (count == CW'(CELL_CYCLES - 1)) begin
            plot_en    <= 1'b0;
            ack        <= '0;
            ack[owner] <= 1'b1;
            state      <= ACK;
          end
        end
        ACK: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_scheduler.sv
// tb/tb_plot_scheduler.sv - randomized self-checking bench for plot_scheduler
module tb_plot_scheduler;

  localparam int NUM  = 3;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int CELL = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [NUM-1:0]    req;
  logic [NUM*XW-1:0] x_req;
  logic [NUM*YW-1:0] y_req;
  logic [NUM*2-1:0]  sel_req;
  logic [NUM-1:0]    ack;
  logic              plot_en;
  logic [XW-1:0]     x_plot;
  logic [YW-1:0]     y_plot;
  logic [1:0]        select;
  logic              busy;
  logic [1:0]        owner;

  plot_scheduler #(
    .NUM_REQ     (NUM),
    .X_W         (XW),
    .Y_W         (YW),
    .CELL_CYCLES (CELL)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .x_req   (x_req),
    .y_req   (y_req),
    .sel_req (sel_req),
    .ack     (ack),
    .plot_en (plot_en),
    .x_plot  (x_plot),
    .y_plot  (y_plot),
    .select  (select),
    .busy    (busy),
    .owner   (owner)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Job-level reference: a job is either absent or has run for m_e cycles since grant.
  bit        m_active = 1'b0;
  int        m_e      = 0;
  int        m_ptr    = 0;
  int        m_owner  = 0;
  logic [XW-1:0] m_x  = '0;
  logic [YW-1:0] m_y  = '0;
  logic [1:0]    m_sel = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  w;
    int  c;
    bit  found;
    w = 0;
    c = 0;
    found = 1'b0;
    if (reset) begin
      m_active = 1'b0;
      m_e      = 0;
      m_ptr    = 0;
      m_owner  = 0;
      m_x      = '0;
      m_y      = '0;
      m_sel    = '0;
    end else if (m_active) begin
      m_e++;
      if (m_e > CELL) m_active = 1'b0;
    end else if (req != '0) begin
      for (int i = 0; i < NUM; i++) begin
        c = (m_ptr + i) % NUM;
        if (!found && (((req >> c) & 3'b001) != 3'b000)) begin
          found = 1'b1;
          w = c;
        end
      end
      m_owner  = w;
      m_x      = XW'(x_req >> (w * XW));
      m_y      = YW'(y_req >> (w * YW));
      m_sel    = 2'(sel_req >> (w * 2));
      m_active = 1'b1;
      m_e      = 0;
      m_ptr    = (w + 1) % NUM;
    end
  endtask

  task automatic compare();
    check("plot_en", 32'(plot_en), 32'(m_active && (m_e < CELL)));
    check("ack", 32'(ack), (m_active && (m_e == CELL)) ? (32'd1 << m_owner) : 32'd0);
    check("busy", 32'(busy), 32'(m_active));
    check("owner", 32'(owner), 32'(m_owner));
    check("x_plot", 32'(x_plot), 32'(m_x));
    check("y_plot", 32'(y_plot), 32'(m_y));
    check("select", 32'(select), 32'(m_sel));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare();
  endtask

  task automatic set_lane(input int i, input int x, input int y, input int s);
    x_req[i*XW +: XW] = XW'(x);
    y_req[i*YW +: YW] = YW'(y);
    sel_req[i*2 +: 2] = 2'(s);
  endtask

  task automatic rand_lane(input int i);
    set_lane(i, int'($urandom_range(159, 0)), int'($urandom_range(119, 0)),
             int'($urandom_range(3, 0)));
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    x_req   = '0;
    y_req   = '0;
    sel_req = '0;
    step();
    step();
    reset = 1'b0;

    // Idle with no requests.
    repeat (20) step();

    // Single job from requester 0.
    set_lane(0, 40, 24, 1);
    req = 3'b001;
    repeat (5) step();
    req = 3'b000;
    repeat (3) step();

    // All requesters held from reset: rotation 0,1,2,...
    reset = 1'b1;
    step();
    for (int i = 0; i < NUM; i++) rand_lane(i);
    req   = 3'b111;
    reset = 1'b0;
    repeat (36) step();
    req = 3'b000;
    repeat (6) step();

    // req1 job leaves pointer at 2; then req1+req2 -> 2 wins, then 1, pointer wraps.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 3'b010;
    step();
    req = 3'b110;
    repeat (16) step();
    req = 3'b000;
    repeat (8) step();

    // Owner changes payload and drops req mid-draw.
    set_lane(0, 40, 10, 2);
    req = 3'b001;
    step();
    step();
    set_lane(0, 99, 77, 3);
    req = 3'b000;
    repeat (6) step();

    // Reset during the second draw cycle, then reissue.
    set_lane(2, 12, 34, 3);
    req = 3'b100;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (8) step();
    req = 3'b000;
    repeat (4) step();

    // Randomized traffic with occasional resets and payload churn.
    repeat (2000) begin
      for (int i = 0; i < NUM; i++) begin
        if ($urandom_range(3, 0) == 0) begin
          if (req[i] == 1'b0) rand_lane(i);
          req[i] = ~req[i];
        end else if ($urandom_range(7, 0) == 0) begin
          rand_lane(i);
        end
      end
      reset = ($urandom_range(199, 0) == 0);
      step();
    end
    reset = 1'b0;
    req   = '0;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/plot_scheduler.md
Name: plot_scheduler

Overview:
Shares the single plothelper/VGA plot port among three drawing requesters:
- req 0: cursor/cell datapath (plot_empty, draw_cell)
- req 1: board_ram disk placement and flips
- req 2: status/score painter

Each requester posts one cell-draw job: x, y and select. The scheduler grants one job at a time, round-robin. It holds the plothelper enable for exactly one cell-draw period, then pulses an ack back to the owner. It replaces the place_disk-driven mux in the top level.

Parameters:
NUM_REQ, 3, number of requesters; fixed ordering 0..NUM_REQ-1.
X_W, 8, x coordinate width (160-pixel screen).
Y_W, 7, y coordinate width (120-pixel screen).
CELL_CYCLES, 256, cycles plothelper needs to paint one cell with enable held high (16x16 cell); must be >= 1.

Ports:
clock  in  1  system clock (CLOCK_50).
reset  in  1  synchronous, active-high reset.
req  in  NUM_REQ  per-requester job request; held high with stable payload until its ack.
x_req  in  NUM_REQ*X_W  flattened x per requester; requester i occupies bits [i*X_W +: X_W].
y_req  in  NUM_REQ*Y_W  flattened y per requester, packed the same way.
sel_req  in  NUM_REQ*2  flattened select/colour code per requester.
ack  out  NUM_REQ  one-cycle completion pulse to the job owner.
plot_en  out  1  enable to plothelper.
x_plot  out  X_W  x_in to plothelper.
y_plot  out  Y_W  y_in to plothelper.
select  out  2  select to plothelper.
busy  out  1  high while a job is in progress (DRAW or ACK).
owner  out  2  index of the current or last granted requester (debug, HEX display).

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - state=IDLE.
  - plot_en=0, ack=0, busy=0, owner=0.
  - x_plot=0, y_plot=0, select=0.
  - rr pointer=0, cycle counter=0.
  - Reset mid-DRAW abandons the job with no ack. The requester must reissue it.
- IDLE:
  - If any req bit is high at an edge, the round-robin winner is chosen. The search starts at the pointer and wraps modulo NUM_REQ.
  - On that edge: x_plot, y_plot, select and owner are registered from the winner's lanes; plot_en=1; busy=1; counter=0; pointer=winner+1 mod NUM_REQ; go to DRAW.
  - If no req is high: stay in IDLE with all outputs held and plot_en=0.
- DRAW:
  - plot_en=1. Coordinates are frozen; changes on the req lanes are ignored.
  - Counter increments each cycle. When counter==CELL_CYCLES-1, the next edge goes to ACK.
  - plot_en is therefore high for exactly CELL_CYCLES consecutive cycles.
- ACK (one cycle):
  - plot_en=0; ack[owner]=1 and all other ack bits are 0; busy=1.
  - Next edge goes to IDLE.
- Latency: req sampled at edge k. plot_en is high for cycles k..k+CELL_CYCLES-1. ack is high in cycle k+CELL_CYCLES. Earliest next grant is at edge k+CELL_CYCLES+2, which is the first IDLE edge.
- Throughput: one job per CELL_CYCLES+2 cycles.
- Fairness: a requester that stays asserted never wins twice in a row while another req is high.
- Boundary conditions:
  - Simultaneous reqs resolve purely by pointer order.
  - Pointer wraps from NUM_REQ-1 to 0.
  - Owner drops req during DRAW: the draw still completes and ack is still pulsed. The requester must tolerate an ack it no longer expects.
  - Requester keeps req high after ack: this is treated as a new job at the next IDLE arbitration.
  - Coordinates are passed through unchecked. Range checking belongs to the requesters.
- At most one ack bit is high in any cycle. ack is never high while plot_en is high.

Decomposition:
- Shared package othello_pkg holds:
  - X_W and Y_W.
  - Select encoding: 2'b00 empty, 2'b01 black, 2'b10 white, 2'b11 cursor highlight.
  - The scheduler state enum: IDLE, DRAW, ACK.
- One sub-module, rr_arbiter:
  - Inputs: req and pointer. Output: one-hot grant plus encoded index.
  - Combinational search, reused later by board_ram flip sequencing.
- The FSM, counter and payload registers stay in plot_scheduler.

Test Plan:
All scenarios use CELL_CYCLES=4.
1. Reset, then req=3'b000 for 20 cycles -> plot_en=0, busy=0, ack=0, x_plot=0, y_plot=0 throughout.
2. req=3'b001 with x=8'd40, y=7'd24, sel=2'b01 at edge k -> x_plot=40, y_plot=24, select=01; plot_en high cycles k..k+3; ack=3'b001 at k+4; busy low at k+5.
3. req=3'b111 held continuously from reset -> grant order 0,1,2,0,1,2; owner sequence matches; one ack every 6 cycles; no requester granted twice consecutively.
4. req1 and req2 present with pointer=2 after a completed req1 job -> req2 wins next, then req1, and the pointer wraps to 0.
5. Owner changes its x_req from 40 to 99 and drops req mid-DRAW -> x_plot stays 40 for all 4 cycles and ack is still pulsed.
6. reset asserted in the 2nd DRAW cycle -> next cycle plot_en=0, ack=0, owner=0, state IDLE; the reissued req is granted normally.
